// File: rtl/mimo_pkg.sv
// Shared types and constants for the MIMO matrix datapath (collect and transpose stages).
package mimo_pkg;

    localparam int unsigned MIMO_N      = 4;
    localparam int unsigned MIMO_DATA_W = 32;

    // Row/column index width and element-counter width; N is a power of two.
    localparam int unsigned MIMO_IDX_W  = $clog2(MIMO_N);
    localparam int unsigned MIMO_CNT_W  = $clog2(MIMO_N * MIMO_N);

    // Named signed element type so that mat[r][c] selects stay signed.
    typedef logic signed [MIMO_DATA_W-1:0] elem_t;
    typedef elem_t [0:MIMO_N-1][0:MIMO_N-1] mat_t;

endpackage

// File: rtl/matrix_bank.sv
// One NxN register bank with a single indexed write port and a parallel read-out.
module matrix_bank
    import mimo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [MIMO_IDX_W-1:0] i_row,
    input  logic [MIMO_IDX_W-1:0] i_col,
    input  elem_t                 i_data,
    output mat_t                  o_mat
);

    mat_t r_mat;

    // Write one element at (row, col); the whole bank clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mat <= '0;
        end else if (i_we) begin
            r_mat[i_row][i_col] <= i_data;
        end
    end

    assign o_mat = r_mat;

endmodule

// File: rtl/matrix_collect.sv
// Serial-to-parallel matrix collector: row-major element stream into a
// ping-pong pair of NxN banks, presented as a whole matrix with valid/ready.
module matrix_collect
    import mimo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  elem_t in_data,
    input  logic  in_last,
    output logic  mat_valid,
    input  logic  mat_ready,
    output mat_t  mat,
    output logic  err
);

    localparam int unsigned LAST_IDX = MIMO_N * MIMO_N - 1;

    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [MIMO_CNT_W-1:0] r_cnt;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_last_idx;
    logic                  w_drain;
    logic                  w_we;
    logic [MIMO_IDX_W-1:0] w_row;
    logic [MIMO_IDX_W-1:0] w_col;
    mat_t                  w_mat [2];

    // Handshakes depend only on registered flags, so there is no in_valid-to-in_ready path.
    assign in_ready   = !r_full[r_wr_bank];
    assign mat_valid  = r_full[r_rd_bank];
    assign mat        = w_mat[r_rd_bank];
    assign err        = r_err;

    assign w_accept   = in_valid && in_ready;
    assign w_drain    = mat_valid && mat_ready;
    assign w_last_idx = (r_cnt == MIMO_CNT_W'(LAST_IDX));

    // Element k lands at row k/N, column k%N; N is a power of two so these are bit fields.
    assign w_row = r_cnt[MIMO_CNT_W-1:MIMO_IDX_W];
    assign w_col = r_cnt[MIMO_IDX_W-1:0];

    // An early in_last element is dropped rather than written.
    assign w_we  = w_accept && (w_last_idx || !in_last);

    // Two banks; only the current fill bank sees the write enable.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        matrix_bank u_bank (
            .clk    (clk),
            .reset  (reset),
            .i_we   (w_we && (r_wr_bank == 1'(b))),
            .i_row  (w_row),
            .i_col  (w_col),
            .i_data (in_data),
            .o_mat  (w_mat[b])
        );
    end

    // Fill counter, full flags, bank pointers and framing-error pulse.
    // A fill always targets an empty bank and a drain a full one, so when both
    // happen in the same cycle they touch different full flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                if (w_last_idx) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= !r_wr_bank;
                    r_cnt             <= '0;
                    r_err             <= !in_last;
                end else if (in_last) begin
                    r_cnt <= '0;
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + MIMO_CNT_W'(1);
                end
            end
            if (w_drain) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= !r_rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_matrix_collect.sv
// Self-checking bench for matrix_collect: directed scenarios plus randomized
// traffic compared every cycle against a queue-based model of the collector.
module tb_matrix_collect;
    import mimo_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  in_valid;
    logic  in_ready;
    elem_t in_data;
    logic  in_last;
    logic  mat_valid;
    logic  mat_ready;
    mat_t  mat;
    logic  err;

    int tests = 0;
    int fails = 0;

    matrix_collect dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .mat       (mat),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Matrix whose element (r,c) is base + N*r + c.
    function automatic mat_t mk(input int base);
        mat_t m;
        for (int r = 0; r < MIMO_N; r++)
            for (int c = 0; c < MIMO_N; c++)
                m[r][c] = elem_t'(base + MIMO_N * r + c);
        return m;
    endfunction

    // ---------------- behavioural model ----------------
    // Completed-but-undelivered matrices in order; at most two can be held.
    mat_t m_q[$];
    mat_t m_cur;
    int   m_cnt   = 0;
    logic m_err   = 1'b0;
    logic chk_en  = 1'b0;

    always @(posedge clk) begin
        logic acc, drn;
        if (reset) begin
            m_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            acc   = in_valid && (m_q.size() < 2);
            drn   = mat_ready && (m_q.size() > 0);
            m_err = 1'b0;
            if (drn) void'(m_q.pop_front());
            if (acc) begin
                if (m_cnt == MIMO_N * MIMO_N - 1) begin
                    m_cur[m_cnt / MIMO_N][m_cnt % MIMO_N] = in_data;
                    m_q.push_back(m_cur);
                    m_cnt = 0;
                    m_err = !in_last;
                end else if (in_last) begin
                    m_cnt = 0;
                    m_err = 1'b1;
                end else begin
                    m_cur[m_cnt / MIMO_N][m_cnt % MIMO_N] = in_data;
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   err_cnt    = 0;
    logic prev_stall = 1'b0;
    mat_t prev_mat;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("in_ready", longint'(in_ready), longint'(m_q.size() < 2));
            chk("mat_valid", longint'(mat_valid), longint'(m_q.size() > 0));
            chk("err", longint'(err), longint'(m_err));
            if (m_q.size() > 0) chk_mat("mat", mat, m_q[0]);
            if (prev_stall) chk_mat("mat_stable", mat, prev_mat);
            prev_stall = mat_valid && !mat_ready;
            prev_mat   = mat;
            if (err) err_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic valid_before;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input elem_t d, input logic last);
        logic rdy;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            @(negedge clk);
            rdy          = in_ready;
            valid_before = mat_valid;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input int base, input int n, input logic last);
        for (int i = 0; i < n; i++)
            send(elem_t'(base + i), last && (i == n - 1));
    endtask

    task automatic drain_all();
        int n = 0;
        mat_ready = 1'b1;
        while (m_q.size() > 0 && n < 100) begin
            cycles(1);
            n++;
        end
        if (m_q.size() > 0) chk("drain_timeout", 0, 1);
        cycles(1);
        mat_ready = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e0;
        int idx;
        int done;
        int budget;
        logic rdy;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mat_ready = 1'b0;
        cycles(3);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_mat_valid", longint'(mat_valid), 0);
        chk("rst_err", longint'(err), 0);
        chk_mat("rst_mat", mat, '0);
        @(posedge clk); #1;

        // 1: single matrix 0..15, consumer always ready
        mat_ready = 1'b1;
        stream(0, 16, 1'b1);
        chk("t1_valid_during_last", longint'(valid_before), 0);
        @(negedge clk);
        chk("t1_valid_after_last", longint'(mat_valid), 1);
        chk_mat("t1_mat", mat, mk(0));
        chk("t1_m33", longint'(mat[3][3]), 15);
        chk("t1_m12", longint'(mat[1][2]), 6);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_valid_drained", longint'(mat_valid), 0);
        chk("t1_no_err", err_cnt, 0);
        @(posedge clk); #1;
        mat_ready = 1'b0;

        // 2: two buffered matrices, backpressure, drain order
        stream(0, 16, 1'b1);
        stream(100, 16, 1'b1);
        in_valid = 1'b1;
        in_data  = elem_t'(200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_full_not_ready", longint'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        mat_ready = 1'b1;
        @(negedge clk);
        chk_mat("t2_first", mat, mk(0));
        @(posedge clk); #1;
        mat_ready = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_drain", longint'(in_ready), 1);
        chk_mat("t2_second", mat, mk(100));
        @(posedge clk); #1;
        stream(200, 16, 1'b1);
        drain_all();

        // 3: early in_last discards partial data
        e0 = err_cnt;
        stream(1000, 6, 1'b1);
        cycles(2);
        chk("t3_err_once", err_cnt - e0, 1);
        stream(50, 16, 1'b1);
        @(negedge clk);
        chk("t3_valid", longint'(mat_valid), 1);
        chk_mat("t3_mat", mat, mk(50));
        @(posedge clk); #1;
        drain_all();

        // 4: missing in_last on the 16th element
        e0 = err_cnt;
        stream(300, 16, 1'b0);
        @(negedge clk);
        chk("t4_err_pulse", longint'(err), 1);
        chk_mat("t4_mat", mat, mk(300));
        @(posedge clk); #1;
        cycles(2);
        chk("t4_err_once", err_cnt - e0, 1);
        drain_all();

        // 5: reset mid-matrix, then signed data
        e0 = err_cnt;
        stream(400, 9, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_valid_in_reset", longint'(mat_valid), 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_reset", longint'(mat_valid), 0);
        chk("t5_ready_after_reset", longint'(in_ready), 1);
        @(posedge clk); #1;
        stream(-7, 16, 1'b1);
        @(negedge clk);
        chk("t5_m00", longint'(mat[0][0]), -7);
        chk("t5_m33", longint'(mat[3][3]), 8);
        chk("t5_no_err", err_cnt - e0, 0);
        @(posedge clk); #1;
        drain_all();

        // 6: random valid/ready traffic, occasional framing errors
        idx    = 0;
        done   = 0;
        budget = 0;
        while (done < 200 && budget < 40000) begin
            in_valid  = 1'($urandom_range(0, 1));
            mat_ready = 1'($urandom_range(0, 1));
            in_data   = elem_t'($urandom);
            if (idx == MIMO_N * MIMO_N - 1) in_last = ($urandom_range(0, 49) != 0);
            else                           in_last = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            budget++;
            if (in_valid && rdy) begin
                if (idx == MIMO_N * MIMO_N - 1) begin
                    idx = 0;
                    done++;
                end else if (in_last) begin
                    idx = 0;
                end else begin
                    idx++;
                end
            end
        end
        chk("t6_matrices_done", done, 200);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
